// File: rtl/isodata_pkg.sv
// isodata_pkg
// Shared definitions for the ISODATA clustering datapath and its iteration
// scheduler: default problem-size constants, the scheduler state encoding
// and width helpers for point-index and iteration-count buses.
package isodata_pkg;

    // Default problem size shared with the assign/update datapath.
    localparam int unsigned ISODATA_N         = 5196; // points per iteration
    localparam int unsigned ISODATA_K         = 10;   // clusters
    localparam int unsigned ISODATA_Q         = 32;   // coordinate width (x1000)
    localparam int unsigned ISODATA_MAX_ITER  = 16;   // passes per run
    localparam int unsigned ISODATA_DRAIN_LAT = 4;    // assign pipeline drain

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        UPDATE,
        CHECK,
        DONE
    } state_t;

    // Width of an index that counts 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold 0..m inclusive.
    function automatic int unsigned iter_w(input int unsigned m);
        return (m <= 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/isodata_idx_counter.sv
// isodata_idx_counter
// Up-counter from 0 to LAST with synchronous clear and count enable. The
// count parks at LAST instead of wrapping, so the index never leaves range.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : advance by one when not already at LAST
//   count    : current value
//   tc       : terminal count, high while count == LAST
module isodata_idx_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned LAST = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    assign tc = (count == W'(LAST));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/isodata_iter_sched.sv
// isodata_iter_sched
// Iteration scheduler for the ISODATA datapath. Each pass clears the cluster
// accumulators, streams point indices 0..N-1 (valid/ready), waits DRAIN_LAT
// cycles for the assignment pipeline to empty, requests a centroid update
// and compares the returned max movement with the captured threshold. Runs
// stop on convergence or after MAX_ITER passes.
// Optional macro ISODATA_PERF_CNT_EN adds stall_cycles / run_cycles.
// Handshake: a point transfers in a cycle where pt_valid && pt_ready are both
//   high at the rising edge; pt_idx is held stable while pt_valid is high and
//   pt_ready is low. upd_req stays high until upd_ack is sampled high.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start, thresh     : run request (IDLE only) and convergence threshold
//   busy, done        : not-idle flag, one-cycle end-of-run pulse
//   converged         : last run stopped on threshold
//   iter_count        : completed passes of the current/last run
//   acc_clr           : one-cycle accumulator clear
//   pt_idx, pt_valid, pt_ready : point stream to the assignment engine
//   upd_req, upd_ack, delta_max : centroid update handshake and result
//   stall_cycles, run_cycles    : perf counters (macro builds only)
//   state_dbg         : current FSM state
module isodata_iter_sched
    import isodata_pkg::*;
#(
    parameter  int unsigned N         = ISODATA_N,
    parameter  int unsigned K         = ISODATA_K,
    parameter  int unsigned Q         = ISODATA_Q,
    parameter  int unsigned MAX_ITER  = ISODATA_MAX_ITER,
    parameter  int unsigned DRAIN_LAT = ISODATA_DRAIN_LAT,
    localparam int unsigned IW        = idx_w(N),
    localparam int unsigned CW        = iter_w(MAX_ITER),
    localparam int unsigned DW        = idx_w(DRAIN_LAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [Q-1:0]  thresh,
    output logic          busy,
    output logic          done,
    output logic          converged,
    output logic [CW-1:0] iter_count,
    output logic          acc_clr,
    output logic [IW-1:0] pt_idx,
    output logic          pt_valid,
    input  logic          pt_ready,
    output logic          upd_req,
    input  logic          upd_ack,
    input  logic [Q-1:0]  delta_max,
`ifdef ISODATA_PERF_CNT_EN
    output logic [31:0]   stall_cycles,
    output logic [31:0]   run_cycles,
`endif
    output state_t        state_dbg
);

    // K only sizes the datapath; here it is just sanity-checked with the rest.
    if (K < 1 || MAX_ITER < 1 || DRAIN_LAT < 1) begin : g_bad_cfg
        $error("isodata_iter_sched: K, MAX_ITER and DRAIN_LAT must be >= 1");
    end

    state_t        state, state_next;
    logic [Q-1:0]  thresh_q;
    logic [Q-1:0]  delta_q;
    logic [CW-1:0] iter_inc;
    logic          pt_tc;
    logic          drain_tc;
    logic [DW-1:0] drain_cnt;
    logic          is_conv;

    assign iter_inc = iter_count + 1'b1;
    assign is_conv  = (delta_q <= thresh_q);

    // pt_idx is cleared on the edge that enters CLEAR so it already reads 0
    // during the CLEAR cycle.
    isodata_idx_counter #(.W(IW), .LAST(N - 1)) u_pt_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_next == CLEAR),
        .en    ((state == STREAM) && pt_ready),
        .count (pt_idx),
        .tc    (pt_tc)
    );

    // Held at 0 outside DRAIN; tc marks the last of DRAIN_LAT cycles.
    isodata_idx_counter #(.W(DW), .LAST(DRAIN_LAT - 1)) u_drain_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state != DRAIN),
        .en    (state == DRAIN),
        .count (drain_cnt),
        .tc    (drain_tc)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = STREAM;
            STREAM:  if (pt_ready && pt_tc) state_next = DRAIN;
            DRAIN:   if (drain_tc) state_next = UPDATE;
            UPDATE:  if (upd_ack) state_next = CHECK;
            CHECK:   state_next = (is_conv || iter_inc == CW'(MAX_ITER)) ? DONE : CLEAR;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            thresh_q   <= '0;
            delta_q    <= '0;
            iter_count <= '0;
            converged  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                thresh_q   <= thresh;
                iter_count <= '0;
                converged  <= 1'b0;
            end
            if (state == UPDATE && upd_ack) begin
                delta_q <= delta_max;
            end
            if (state == CHECK) begin
                iter_count <= iter_inc;
                if (is_conv) converged <= 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign acc_clr   = (state == CLEAR);
    assign pt_valid  = (state == STREAM);
    assign upd_req   = (state == UPDATE);
    assign state_dbg = state;

`ifdef ISODATA_PERF_CNT_EN
    // Both counters saturate; run_cycles covers CLEAR through DONE.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            stall_cycles <= '0;
            run_cycles   <= '0;
        end else begin
            if (state == STREAM && !pt_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
            if (state != IDLE && run_cycles != '1)
                run_cycles <= run_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_isodata_iter_sched.sv
// Bench for isodata_iter_sched (N=8, MAX_ITER=4, DRAIN_LAT=2, Q=32).
// Each run is expanded up front into a per-cycle trace: the stimulus for the
// cycle and the outputs the scheduler must show in that cycle, derived from
// the pass structure (clear, N accepted points with random stalls, drain,
// update with random ack delay, check, done) and the convergence rule.
module tb_isodata_iter_sched;
    import isodata_pkg::*;

    localparam int unsigned N         = 8;
    localparam int unsigned K         = 10;
    localparam int unsigned Q         = 32;
    localparam int unsigned MAX_ITER  = 4;
    localparam int unsigned DRAIN_LAT = 2;
    localparam int unsigned IW        = 3;
    localparam int unsigned CW        = 3;
    localparam int unsigned EW        = 6 + IW + CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, pt_ready, upd_ack;
    logic [Q-1:0]  thresh, delta_max;
    logic          busy, done, converged, acc_clr, pt_valid, upd_req;
    logic [CW-1:0] iter_count;
    logic [IW-1:0] pt_idx;
    state_t        state_dbg;
`ifdef ISODATA_PERF_CNT_EN
    logic [31:0]   stall_cycles, run_cycles;
`endif

    isodata_iter_sched #(
        .N(N), .K(K), .Q(Q), .MAX_ITER(MAX_ITER), .DRAIN_LAT(DRAIN_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .thresh(thresh),
        .busy(busy), .done(done), .converged(converged),
        .iter_count(iter_count), .acc_clr(acc_clr),
        .pt_idx(pt_idx), .pt_valid(pt_valid), .pt_ready(pt_ready),
        .upd_req(upd_req), .upd_ack(upd_ack), .delta_max(delta_max),
`ifdef ISODATA_PERF_CNT_EN
        .stall_cycles(stall_cycles), .run_cycles(run_cycles),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- trace / scoreboard ----------------
    typedef struct {
        logic         rst, start, pt_ready, upd_ack, chk_perf;
        logic [Q-1:0] thresh, delta_max;
        int           exp_stall, exp_run;
    } stim_t;

    stim_t            stim_q[$];
    logic [EW-1:0]    exp_q[$];
    logic [EW-1:0]    msk_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // model state carried between runs
    int   m_iter     = 0;
    logic m_conv     = 1'b0;
    logic m_idx_zero = 1'b1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic stim_t quiet_stim();
        stim_t s;
        s.rst = 1'b0; s.start = 1'b0; s.pt_ready = 1'($urandom_range(1, 0));
        s.upd_ack = 1'b0; s.chk_perf = 1'b0;
        s.thresh = $urandom; s.delta_max = $urandom;
        s.exp_stall = 0; s.exp_run = 0;
        return s;
    endfunction

    // In-run noise: start, ack, ready and data toggle freely; all must be ignored.
    function automatic stim_t noisy_stim();
        stim_t s;
        s = quiet_stim();
        s.start   = ($urandom_range(3, 0) == 0);
        s.upd_ack = 1'($urandom_range(1, 0));
        return s;
    endfunction

    task automatic add_cycle(input stim_t s, input logic b, input logic d, input logic c,
                             input logic a, input logic pv, input logic ur,
                             input int idx, input logic idx_chk, input int iter);
        logic [EW-1:0] e, m;
        e = {b, d, c, a, pv, ur, IW'(idx), CW'(iter)};
        m = '1;
        if (!idx_chk) m[CW +: IW] = '0;
        stim_q.push_back(s);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    // One run: th = threshold, deltas = per-pass update result,
    // abort_idx >= 0 asserts reset while that index is offered in pass 0.
    task automatic add_run(input logic [Q-1:0] th, input logic [Q-1:0] deltas[MAX_ITER],
                           input int max_stall, input int max_ack, input int abort_idx);
        stim_t s;
        int    p, stall, run, ns, nd;
        logic  stop;
        s = quiet_stim(); s.start = 1'b1; s.thresh = th;
        add_cycle(s, 0, 0, m_conv, 0, 0, 0, 0, m_idx_zero, m_iter);
        m_conv = 1'b0; stall = 0; run = 0; p = 0; stop = 1'b0;
        while (!stop) begin
            s = noisy_stim();
            add_cycle(s, 1, 0, 0, 1, 0, 0, 0, 1, p); run++;
            for (int i = 0; i < int'(N); i++) begin
                ns = $urandom_range(max_stall, 0);
                for (int j = 0; j < ns; j++) begin
                    s = noisy_stim(); s.pt_ready = 1'b0;
                    add_cycle(s, 1, 0, 0, 0, 1, 0, i, 1, p); stall++; run++;
                end
                s = noisy_stim(); s.pt_ready = 1'b1;
                if (p == 0 && i == abort_idx) s.rst = 1'b1;
                add_cycle(s, 1, 0, 0, 0, 1, 0, i, 1, p); run++;
                if (s.rst) begin
                    m_iter = 0; m_conv = 1'b0; m_idx_zero = 1'b1;
                    return;
                end
            end
            for (int j = 0; j < int'(DRAIN_LAT); j++) begin
                s = noisy_stim();
                add_cycle(s, 1, 0, 0, 0, 0, 0, 0, 0, p); run++;
            end
            nd = $urandom_range(max_ack, 0);
            for (int j = 0; j < nd; j++) begin
                s = noisy_stim(); s.upd_ack = 1'b0;
                add_cycle(s, 1, 0, 0, 0, 0, 1, 0, 0, p); run++;
            end
            s = noisy_stim(); s.upd_ack = 1'b1; s.delta_max = deltas[p];
            add_cycle(s, 1, 0, 0, 0, 0, 1, 0, 0, p); run++;
            s = noisy_stim();
            add_cycle(s, 1, 0, 0, 0, 0, 0, 0, 0, p); run++;
            if (deltas[p] <= th) begin
                m_conv = 1'b1; stop = 1'b1;
            end else if (p + 1 == int'(MAX_ITER)) begin
                stop = 1'b1;
            end
            p++;
        end
        m_iter = p;
        s = noisy_stim();
        add_cycle(s, 1, 1, m_conv, 0, 0, 0, 0, 0, m_iter); run++;
        m_idx_zero = 1'b0;
        s = quiet_stim(); s.chk_perf = 1'b1; s.exp_stall = stall; s.exp_run = run;
        add_cycle(s, 0, 0, m_conv, 0, 0, 0, 0, 0, m_iter);
    endtask

    // ---------------- driver / main ----------------
    logic [Q-1:0] d[MAX_ITER];
    logic [Q-1:0] th;

    initial begin
        stim_t         s;
        logic [EW-1:0] e, m, got;
        int            cyc;

        rst = 1'b1; start = 1'b0; thresh = '0; pt_ready = 1'b0;
        upd_ack = 1'b0; delta_max = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        check("rst_outs", 64'({busy, done, converged, acc_clr, pt_valid, upd_req, pt_idx, iter_count}), 64'(0));
        @(posedge clk); #1;

        // immediate convergence, ready high, ack immediate
        d = '{32'd5, 32'd5, 32'd5, 32'd5};
        add_run(32'd10, d, 0, 0, -1);
        // never converges: MAX_ITER passes
        d = '{32'd1000, 32'd1000, 32'd1000, 32'd1000};
        add_run(32'd10, d, 0, 0, -1);
        // equality converges, with stalls and late ack
        d = '{32'd50, 32'd1000, 32'd1000, 32'd1000};
        add_run(32'd50, d, 1, 5, -1);
        // reset mid-stream, then a clean pass
        d = '{32'd1000, 32'd1000, 32'd1000, 32'd1000};
        add_run(32'd10, d, 0, 0, 3);
        d = '{32'd5, 32'd5, 32'd5, 32'd5};
        add_run(32'd10, d, 0, 5, -1);
        // full-width unsigned compares
        d = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
        add_run(32'h8000_0000, d, 2, 3, -1);
        d = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        add_run(32'hFFFF_FFFF, d, 0, 0, -1);
        // randomized runs
        for (int r = 0; r < 24; r++) begin
            th = $urandom_range(100, 0);
            for (int k = 0; k < int'(MAX_ITER); k++) d[k] = $urandom_range(130, 0);
            add_run(th, d, 2, 5, -1);
        end

        cyc = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            rst = s.rst; start = s.start; thresh = s.thresh; pt_ready = s.pt_ready;
            upd_ack = s.upd_ack; delta_max = s.delta_max;
            @(negedge clk);
            got = {busy, done, converged, acc_clr, pt_valid, upd_req, pt_idx, iter_count};
            check($sformatf("outs@%0d", cyc), 64'(got & m), 64'(e & m));
`ifdef ISODATA_PERF_CNT_EN
            if (s.chk_perf) begin
                check($sformatf("stall_cycles@%0d", cyc), 64'(stall_cycles), 64'(s.exp_stall));
                check($sformatf("run_cycles@%0d", cyc), 64'(run_cycles), 64'(s.exp_run));
            end
`endif
            @(posedge clk); #1;
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
